opctrl_delay_line: RTL and testbench
====================================

OPCTRL_DELAY_LINE -- requirements
Module: opctrl_delay_line

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 3, number of register stages (2..16).
REQ-003 Localparam TSW = clog2(DEPTH); localparam OCW = clog2(DEPTH+1).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Clock  input  1  rising-edge clock for all state.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Din  input  WIDTH  data word entering stage 0.
REQ-008 DinValid  input  1  Din carries a valid word this cycle.
REQ-009 Stall  input  1  freeze all stages this cycle.
REQ-010 Flush  input  1  invalidate all stages at next edge.
REQ-011 TapSel  input  TSW  output tap; delay = min(TapSel, DEPTH-1) + 1 cycles.
REQ-012 Dout  output  WIDTH  data of the selected stage.
REQ-013 DoutValid  output  1  valid bit of the selected stage.
REQ-014 Occupancy  output  OCW  count of valid stages, 0..DEPTH.

Function
REQ-015 Each stage k SHALL hold a WIDTH data register D[k] and a valid bit V[k].
REQ-016 Advance: Stall=0 and Flush=0 -> D[0]<=Din, V[0]<=DinValid, D[k]<=D[k-1], V[k]<=V[k-1] for k=1..DEPTH-1.
REQ-017 Stall=1 and Flush=0 -> all D and V hold; Din/DinValid are dropped for that cycle.
REQ-018 Flush=1 -> all V cleared at the next edge regardless of Stall and DinValid; D registers hold.
REQ-019 Flush takes priority over Stall; DinValid coincident with Flush is discarded.
REQ-020 Dout = D[t], DoutValid = V[t], t = min(TapSel, DEPTH-1); combinational mux from registers, no added latency.
REQ-021 TapSel >= DEPTH SHALL clamp to DEPTH-1, never index out of range.
REQ-022 TapSel changes take effect the same cycle; no realignment; words between the old and new taps may be skipped or repeated.
REQ-023 Occupancy = popcount(V[0..DEPTH-1]), combinational, reflecting current register state.
REQ-024 Invalid words still propagate data; only V marks them as bubbles.
REQ-025 With Stall=0, Flush=0 and TapSel=DEPTH-1, behaviour matches a plain DEPTH-stage delay of Din.

Reset
REQ-026 Reset=1 SHALL asynchronously clear every D[k] to 0 and every V[k] to 0.
REQ-027 During and after reset: Dout=0, DoutValid=0, Occupancy=0 until the first advancing edge after Reset deasserts.
REQ-028 Reset asserted mid-stream discards all in-flight words; no partial state survives.
REQ-029 Inputs sampled on the edge where Reset is high SHALL have no effect.

Structure
REQ-030 Package opctrl_pkg SHALL hold OPC_WIDTH_DEF=32, OPC_DEPTH_DEF=3, OPC_DEPTH_MAX=16 and the clog2 helper function.
REQ-031 One sub-module opctrl_dly_stage (data + valid register with hold, flush and async reset) SHALL be instantiated DEPTH times via a generate loop.
REQ-032 Tap mux, clamp and popcount SHALL reside in the top module; illegal WIDTH/DEPTH SHALL fail elaboration.

Verification
REQ-033 Default params, TapSel=2, Din=0x11,0x22,0x33,0x44 with DinValid=1 on consecutive cycles -> Dout=0x11 three edges after first input, then 0x22,0x33,0x44, DoutValid=1; Occupancy ramps 1,2,3.
REQ-034 Stream 0xA0..0xA5, Stall=1 for 2 cycles after 0xA2 -> Dout sequence stretches with two repeats, no word lost except Din presented during stall; Occupancy constant while stalled.
REQ-035 Pipeline full (Occupancy=3), Flush=1 with Stall=1 and DinValid=1 -> next edge Occupancy=0, DoutValid=0; Dout data unchanged.
REQ-036 DEPTH=5, TapSel swept 0..7 with constant stream -> delay 1..5, TapSel 5..7 behave as 4.
REQ-037 Reset pulse asserted between edges with Occupancy=3 -> Dout=0, DoutValid=0, Occupancy=0 immediately without a clock edge; restart latency equals 1+TapSel.
REQ-038 WIDTH=8, DEPTH=16, random Din/DinValid/Stall/Flush for 10000 cycles -> outputs match a reference queue model every cycle.

Source files
------------

// File: rtl/opctrl_pkg.sv
// ============================================================================
// opctrl_pkg : shared defaults, limits and the clog2 helper for the delay line
// Revision   : 1.0
// ============================================================================
`default_nettype none

package opctrl_pkg;

   localparam int OPC_WIDTH_DEF = 32;
   localparam int OPC_DEPTH_DEF = 3;
   localparam int OPC_DEPTH_MAX = 16;
   localparam int OPC_WIDTH_MAX = 64;

   // Ceiling log2, evaluated at elaboration for port and counter widths.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : opctrl_pkg

`default_nettype wire

// File: rtl/opctrl_dly_stage.sv
// ============================================================================
// opctrl_dly_stage : one data + valid register with advance, flush, async reset
// Revision         : 1.0
// ============================================================================
`default_nettype none

module opctrl_dly_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_adv,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_v,
   output logic [WIDTH-1:0] o_d,
   output logic             o_v
);

   logic [WIDTH-1:0] r_d;
   logic             r_v;

   // Flush only kills the valid bit; the data word is left in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d <= '0;
         r_v <= 1'b0;
      end else if (i_flush) begin
         r_v <= 1'b0;
      end else if (i_adv) begin
         r_d <= i_d;
         r_v <= i_v;
      end
   end

   assign o_d = r_d;
   assign o_v = r_v;

endmodule : opctrl_dly_stage

`default_nettype wire

// File: rtl/opctrl_delay_line.sv
// ============================================================================
// opctrl_delay_line : DEPTH-stage stallable/flushable delay line with tap mux
// Revision          : 1.0
// ============================================================================
`default_nettype none

module opctrl_delay_line
   import opctrl_pkg::*;
#(
   parameter  int WIDTH = OPC_WIDTH_DEF,
   parameter  int DEPTH = OPC_DEPTH_DEF,
   localparam int TSW   = clog2(DEPTH),
   localparam int OCW   = clog2(DEPTH + 1)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Din,
   input  logic             DinValid,
   input  logic             Stall,
   input  logic             Flush,
   input  logic [TSW-1:0]   TapSel,
   output logic [WIDTH-1:0] Dout,
   output logic             DoutValid,
   output logic [OCW-1:0]   Occupancy
);

   localparam logic [TSW-1:0] c_tap_max = TSW'(DEPTH - 1);

   logic [WIDTH-1:0] w_d_in [DEPTH];
   logic [WIDTH-1:0] w_d    [DEPTH];
   logic [DEPTH-1:0] w_v_in;
   logic [DEPTH-1:0] w_v;
   logic             w_adv;
   logic [TSW-1:0]   w_tap;
   logic [OCW-1:0]   w_occ;

   if ((WIDTH < 1) || (WIDTH > OPC_WIDTH_MAX) ||
       (DEPTH < 2) || (DEPTH > OPC_DEPTH_MAX)) begin : g_bad_param
      $error("opctrl_delay_line: WIDTH must be 1..64 and DEPTH 2..16");
   end

   assign w_adv = ~Stall;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign w_d_in[k] = Din;
         assign w_v_in[k] = DinValid;
      end else begin : g_body
         assign w_d_in[k] = w_d[k-1];
         assign w_v_in[k] = w_v[k-1];
      end

      opctrl_dly_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (Clock),
         .rst     (Reset),
         .i_adv   (w_adv),
         .i_flush (Flush),
         .i_d     (w_d_in[k]),
         .i_v     (w_v_in[k]),
         .o_d     (w_d[k]),
         .o_v     (w_v[k])
      );
   end

   // Out-of-range taps saturate at the last stage.
   assign w_tap     = (TapSel > c_tap_max) ? c_tap_max : TapSel;
   assign Dout      = w_d[w_tap];
   assign DoutValid = w_v[w_tap];

   always_comb begin
      w_occ = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_occ = w_occ + OCW'(w_v[k]);
      end
   end

   assign Occupancy = w_occ;

endmodule : opctrl_delay_line

`default_nettype wire

// File: tb/tb_opctrl_delay_line.sv
// ============================================================================
// tb_opctrl_delay_line : scoreboard bench over DEPTH=3, 5 and 16 instances
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_opctrl_delay_line;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] din;
   logic        dv, stall, flush;
   logic [1:0]  tap3;
   logic [2:0]  tap5;
   logic [3:0]  tap16;

   logic [31:0] dout3;
   logic [15:0] dout5;
   logic [7:0]  dout16;
   logic        dv3, dv5, dv16;
   logic [1:0]  occ3;
   logic [2:0]  occ5;
   logic [4:0]  occ16;

   always #5 clk = ~clk;

   opctrl_delay_line u_d3 (
      .Clock (clk), .Reset (rst), .Din (din[31:0]), .DinValid (dv),
      .Stall (stall), .Flush (flush), .TapSel (tap3),
      .Dout (dout3), .DoutValid (dv3), .Occupancy (occ3)
   );

   opctrl_delay_line #(.WIDTH(16), .DEPTH(5)) u_d5 (
      .Clock (clk), .Reset (rst), .Din (din[15:0]), .DinValid (dv),
      .Stall (stall), .Flush (flush), .TapSel (tap5),
      .Dout (dout5), .DoutValid (dv5), .Occupancy (occ5)
   );

   opctrl_delay_line #(.WIDTH(8), .DEPTH(16)) u_d16 (
      .Clock (clk), .Reset (rst), .Din (din[7:0]), .DinValid (dv),
      .Stall (stall), .Flush (flush), .TapSel (tap16),
      .Dout (dout16), .DoutValid (dv16), .Occupancy (occ16)
   );

   typedef struct packed {
      logic [63:0] d;
      logic        v;
      logic [31:0] occ;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb [$];
   int          dep [NI] = '{3, 5, 16};
   logic [63:0] msk [NI] = '{64'hFFFF_FFFF, 64'hFFFF, 64'hFF};
   logic [63:0] md  [NI][16];
   logic        mv  [NI][16];
   int          n;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int tap_of(input int i);
      case (i)
         0:       return int'(tap3);
         1:       return int'(tap5);
         default: return int'(tap16);
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < 16; k++) begin
            md[i][k] = '0;
            mv[i][k] = 1'b0;
         end
      end
   endtask

   // Reference stage array updated with the inputs present at the coming edge.
   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            for (int k = 0; k < 16; k++) begin
               md[i][k] = '0;
               mv[i][k] = 1'b0;
            end
         end else if (flush) begin
            for (int k = 0; k < 16; k++) mv[i][k] = 1'b0;
         end else if (!stall) begin
            for (int k = dep[i] - 1; k > 0; k--) begin
               md[i][k] = md[i][k-1];
               mv[i][k] = mv[i][k-1];
            end
            md[i][0] = din & msk[i];
            mv[i][0] = dv;
         end
      end
   endtask

   task automatic push_expected();
      exp_t e;
      int   t;
      for (int i = 0; i < NI; i++) begin
         t = tap_of(i);
         if (t > dep[i] - 1) t = dep[i] - 1;
         e.d   = md[i][t];
         e.v   = mv[i][t];
         e.occ = 0;
         for (int k = 0; k < dep[i]; k++) e.occ = e.occ + 32'(mv[i][k]);
         sb.push_back(e);
      end
   endtask

   task automatic compare_outputs();
      exp_t e;
      for (int i = 0; i < NI; i++) begin
         if (sb.size() == 0) begin
            check_val("sb_empty", 64'd0, 64'd1);
            return;
         end
         e = sb.pop_front();
         case (i)
            0: begin
               check_val("d3_dout", 64'(dout3), e.d);
               check_val("d3_vld",  64'(dv3),   64'(e.v));
               check_val("d3_occ",  64'(occ3),  64'(e.occ));
            end
            1: begin
               check_val("d5_dout", 64'(dout5), e.d);
               check_val("d5_vld",  64'(dv5),   64'(e.v));
               check_val("d5_occ",  64'(occ5),  64'(e.occ));
            end
            default: begin
               check_val("d16_dout", 64'(dout16), e.d);
               check_val("d16_vld",  64'(dv16),   64'(e.v));
               check_val("d16_occ",  64'(occ16),  64'(e.occ));
            end
         endcase
      end
   endtask

   task automatic step();
      model_edge();
      push_expected();
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic drive(input logic [63:0] d, input logic v,
                        input logic s = 1'b0, input logic f = 1'b0);
      din   = d;
      dv    = v;
      stall = s;
      flush = f;
      step();
   endtask

   initial begin
      rst = 1'b1; din = '0; dv = 1'b0; stall = 1'b0; flush = 1'b0;
      tap3 = 2'd2; tap5 = 3'd4; tap16 = 4'd15;
      model_clear();
      @(posedge clk); #1;

      // Inputs sampled while reset is high must be ignored.
      drive(64'h55, 1'b1);
      check_val("rst_dout3", 64'(dout3), 64'd0);
      check_val("rst_vld3",  64'(dv3),   64'd0);
      check_val("rst_occ16", 64'(occ16), 64'd0);
      rst = 1'b0;

      // Basic 3-cycle delay at TapSel=2.
      drive(64'h11, 1'b1); check_val("ramp_occ1", 64'(occ3), 64'd1);
      drive(64'h22, 1'b1); check_val("ramp_occ2", 64'(occ3), 64'd2);
      drive(64'h33, 1'b1); check_val("ramp_occ3", 64'(occ3), 64'd3);
      check_val("seq_11", 64'(dout3), 64'h11);
      check_val("seq_vld", 64'(dv3), 64'd1);
      drive(64'h44, 1'b1); check_val("seq_22", 64'(dout3), 64'h22);
      drive(64'h0, 1'b0);  check_val("seq_33", 64'(dout3), 64'h33);
      drive(64'h0, 1'b0);  check_val("seq_44", 64'(dout3), 64'h44);
      check_val("seq_44_vld", 64'(dv3), 64'd1);

      // Two-cycle stall after 0xA2; stalled input 0xEE is dropped.
      drive(64'hA0, 1'b1);
      drive(64'hA1, 1'b1);
      drive(64'hA2, 1'b1); check_val("stl_a0", 64'(dout3), 64'hA0);
      drive(64'hEE, 1'b1, 1'b1); check_val("stl_rep1", 64'(dout3), 64'hA0);
      check_val("stl_occ1", 64'(occ3), 64'd3);
      drive(64'hEE, 1'b1, 1'b1); check_val("stl_rep2", 64'(dout3), 64'hA0);
      check_val("stl_occ2", 64'(occ3), 64'd3);
      drive(64'hA3, 1'b1); check_val("stl_a1", 64'(dout3), 64'hA1);
      drive(64'hA4, 1'b1); check_val("stl_a2", 64'(dout3), 64'hA2);
      drive(64'hA5, 1'b1); check_val("stl_a3", 64'(dout3), 64'hA3);
      check_val("full_occ", 64'(occ3), 64'd3);

      // Flush beats stall and DinValid; data registers keep their contents.
      drive(64'hFF, 1'b1, 1'b1, 1'b1);
      check_val("fl_occ",  64'(occ3), 64'd0);
      check_val("fl_vld",  64'(dv3),  64'd0);
      check_val("fl_dout", 64'(dout3), 64'hA3);

      // Same-cycle tap changes, including the clamp of TapSel=3.
      drive(64'hB0, 1'b1);
      drive(64'hB1, 1'b1);
      drive(64'hB2, 1'b1);
      tap3 = 2'd0; #1; check_val("tap0", 64'(dout3), 64'hB2);
      tap3 = 2'd1; #1; check_val("tap1", 64'(dout3), 64'hB1);
      tap3 = 2'd3; #1; check_val("tap_clamp", 64'(dout3), 64'hB0);
      tap3 = 2'd2;

      // DEPTH=5 tap sweep: delay is min(TapSel,4)+1 on a counting stream.
      n = 0;
      for (int t = 0; t < 8; t++) begin
         tap5 = 3'(t);
         for (int r = 0; r < 6; r++) begin
            n++;
            drive(64'(n), 1'b1);
            check_val("sweep_d5", 64'(dout5), 64'(n - ((t > 4) ? 4 : t)));
            check_val("sweep_v5", 64'(dv5), 64'd1);
         end
      end

      // Asynchronous reset between edges with a full pipe.
      rst = 1'b1; #1;
      check_val("arst_dout3", 64'(dout3), 64'd0);
      check_val("arst_vld3",  64'(dv3),   64'd0);
      check_val("arst_occ3",  64'(occ3),  64'd0);
      check_val("arst_occ5",  64'(occ5),  64'd0);
      check_val("arst_occ16", 64'(occ16), 64'd0);
      #1; rst = 1'b0;
      model_clear();
      drive(64'hC1, 1'b1); check_val("rs_v1", 64'(dv3), 64'd0);
      check_val("rs_occ1", 64'(occ3), 64'd1);
      drive(64'h0, 1'b0);  check_val("rs_v2", 64'(dv3), 64'd0);
      drive(64'h0, 1'b0);  check_val("rs_c1", 64'(dout3), 64'hC1);
      check_val("rs_v3", 64'(dv3), 64'd1);

      // Randomised traffic against the reference model.
      for (int c = 0; c < 10000; c++) begin
         din   = {32'($urandom), 32'($urandom)};
         dv    = 1'($urandom);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 31) == 0);
         tap3  = 2'($urandom);
         tap5  = 3'($urandom);
         tap16 = 4'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_opctrl_delay_line

`default_nettype wire
